// File: rtl/ili_window_fill.sv
// Window-fill byte source for the ILI9341 transmit path: emits CASET, PASET, RAMWR
// and the pixel stream for one solid RGB565 rectangle over the send/done byte handshake.
module ili_window_fill #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [8:0]  i_x0,
  input  logic [8:0]  i_x1,
  input  logic [8:0]  i_y0,
  input  logic [8:0]  i_y1,
  input  logic [15:0] i_color,
  input  logic        i_byte_done,
  output logic        o_send,
  output logic [7:0]  o_data,
  output logic        o_dc,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [9:0] XLIM = 10'(WIDTH);
  localparam logic [9:0] YLIM = 10'(HEIGHT);
  localparam logic [3:0] SEQ_PIX = 4'd11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

  state_t      state;
  logic [8:0]  x0_q, x1_q, y0_q, y1_q;
  logic [15:0] color_q;
  logic [3:0]  seq;
  logic [8:0]  col, row;
  logic        lo;

  logic        req_ok;
  logic [3:0]  seq_nxt;
  logic [7:0]  hdr_byte;
  logic        last_pixel;

  always_comb begin
    req_ok = (i_x0 <= i_x1) && (i_y0 <= i_y1) &&
             ({1'b0, i_x1} < XLIM) && ({1'b0, i_y1} < YLIM);
    seq_nxt = seq + 4'd1;
    hdr_byte = 8'h00;
    // Header byte following the one just acknowledged; coordinates zero-extended to 16 bits.
    case (seq_nxt)
      4'd1:    hdr_byte = {7'd0, x0_q[8]};
      4'd2:    hdr_byte = x0_q[7:0];
      4'd3:    hdr_byte = {7'd0, x1_q[8]};
      4'd4:    hdr_byte = x1_q[7:0];
      4'd5:    hdr_byte = 8'h2B;
      4'd6:    hdr_byte = {7'd0, y0_q[8]};
      4'd7:    hdr_byte = y0_q[7:0];
      4'd8:    hdr_byte = {7'd0, y1_q[8]};
      4'd9:    hdr_byte = y1_q[7:0];
      4'd10:   hdr_byte = 8'h2C;
      default: hdr_byte = 8'h00;
    endcase
    last_pixel = lo && (col == x1_q) && (row == y1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      seq     <= '0;
      col     <= '0;
      row     <= '0;
      lo      <= 1'b0;
      o_send  <= 1'b0;
      o_data  <= 8'h00;
      o_dc    <= 1'b0;
      o_cs    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_err <= 1'b0;
          if (i_start) begin
            x0_q    <= i_x0;
            x1_q    <= i_x1;
            y0_q    <= i_y0;
            y1_q    <= i_y1;
            color_q <= i_color;
            seq     <= '0;
            col     <= i_x0;
            row     <= i_y0;
            lo      <= 1'b0;
            if (req_ok) begin
              state  <= SEND;
              o_send <= 1'b1;
              o_data <= 8'h2A;
              o_dc   <= 1'b0;
              o_cs   <= 1'b0;
              o_busy <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        SEND: begin
          o_send <= 1'b0;
          state  <= WAIT;
        end

        WAIT: begin
          if (i_byte_done) begin
            if (seq != SEQ_PIX) begin
              seq    <= seq_nxt;
              state  <= SEND;
              o_send <= 1'b1;
              if (seq == 4'd10) begin
                o_data <= color_q[15:8];
                o_dc   <= 1'b1;
                lo     <= 1'b0;
              end else begin
                o_data <= hdr_byte;
                o_dc   <= !((seq_nxt == 4'd5) || (seq_nxt == 4'd10));
              end
            end else if (!lo) begin
              lo     <= 1'b1;
              state  <= SEND;
              o_send <= 1'b1;
              o_data <= color_q[7:0];
              o_dc   <= 1'b1;
            end else if (last_pixel) begin
              state  <= FINISH;
              o_cs   <= 1'b1;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              // Column counter runs inside the row counter, wrapping back to x0.
              lo <= 1'b0;
              if (col == x1_q) begin
                col <= x0_q;
                row <= row + 9'd1;
              end else begin
                col <= col + 9'd1;
              end
              state  <= SEND;
              o_send <= 1'b1;
              o_data <= color_q[15:8];
              o_dc   <= 1'b1;
            end
          end
        end

        FINISH: begin
          o_done <= 1'b0;
          seq    <= '0;
          lo     <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili_window_fill.sv
// Directed and randomized window fills checked against a byte-stream model
// built directly from the window coordinates and colour.
module tb_ili_window_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [8:0]  i_x0, i_x1, i_y0, i_y1;
  logic [15:0] i_color;
  logic        i_byte_done;
  logic        o_send;
  logic [7:0]  o_data;
  logic        o_dc;
  logic        o_cs;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;

  ili_window_fill #(.WIDTH(240), .HEIGHT(320)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_color(i_color), .i_byte_done(i_byte_done),
    .o_send(o_send), .o_data(o_data), .o_dc(o_dc), .o_cs(o_cs),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Control snapshot {send, cs, busy, done, err}.
  function automatic logic [31:0] ctl();
    return 32'({o_send, o_cs, o_busy, o_done, o_err});
  endfunction

  task automatic do_fill(input int x0, input int x1, input int y0, input int y1,
                         input logic [15:0] color, input int max_lat,
                         input bit pokes, input int abort_at);
    logic [7:0] q[$];
    bit         dq[$];
    int         n;
    int         lat;
    q  = '{8'h2A, 8'(x0 >> 8), 8'(x0), 8'(x1 >> 8), 8'(x1),
           8'h2B, 8'(y0 >> 8), 8'(y0), 8'(y1 >> 8), 8'(y1), 8'h2C};
    dq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n  = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int i = 0; i < n; i++) begin
      q.push_back(color[15:8]);
      q.push_back(color[7:0]);
      dq.push_back(1'b1);
      dq.push_back(1'b1);
    end

    i_x0 = 9'(x0); i_x1 = 9'(x1); i_y0 = 9'(y0); i_y1 = 9'(y1);
    i_color = color;
    i_start = 1'b1;
    step;
    i_start = 1'b0;
    // Inputs change after the latch; the stream must not follow them.
    i_x0 = 9'($urandom); i_x1 = 9'($urandom); i_y0 = 9'($urandom); i_y1 = 9'($urandom);
    i_color = 16'($urandom);

    for (int k = 0; k < q.size(); k++) begin
      chk($sformatf("byte%0d", k), 32'({o_send, o_cs, o_busy, o_dc, o_data}),
          32'({1'b1, 1'b0, 1'b1, dq[k], q[k]}));
      if (k == abort_at) begin
        rst = 1'b0;
        step;
        rst = 1'b1;
        chk("abort", 32'({ctl(), o_dc, o_data}), 32'({5'b01000, 1'b0, 8'h00}));
        step;
        chk("abort_idle", 32'({ctl(), o_dc, o_data}), 32'({5'b01000, 1'b0, 8'h00}));
        return;
      end
      if (pokes) begin
        i_byte_done = 1'b1;
        i_start = 1'b1;
      end
      step;
      i_byte_done = 1'b0;
      i_start = 1'b0;
      lat = $urandom_range(max_lat, 1);
      for (int j = 0; j < lat; j++) begin
        chk("hold", 32'({o_send, o_cs, o_busy, o_dc, o_data}),
            32'({1'b0, 1'b0, 1'b1, dq[k], q[k]}));
        if (pokes && j == 0) i_start = 1'b1;
        if (j == lat - 1) i_byte_done = 1'b1;
        step;
        i_start = 1'b0;
        i_byte_done = 1'b0;
      end
    end
    chk("finish", ctl(), 32'(5'b01010));
    if (pokes) i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("post_idle", ctl(), 32'(5'b01000));
  endtask

  task automatic do_reject(input int x0, input int x1, input int y0, input int y1);
    i_x0 = 9'(x0); i_x1 = 9'(x1); i_y0 = 9'(y0); i_y1 = 9'(y1);
    i_color = 16'($urandom);
    i_start = 1'b1;
    step;
    i_start = 1'b0;
    chk("reject", ctl(), 32'(5'b01001));
    step;
    chk("reject_after", ctl(), 32'(5'b01000));
  endtask

  initial begin
    int x0, y0;
    rst = 1'b0;
    i_start = 1'b0;
    i_byte_done = 1'b0;
    i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0;
    i_color = '0;
    repeat (3) step;
    chk("reset", 32'({ctl(), o_dc, o_data}), 32'({5'b01000, 1'b0, 8'h00}));
    rst = 1'b1;
    step;

    do_fill(0, 0, 0, 0, 16'hF800, 3, 1'b0, -1);
    do_fill(10, 11, 300, 301, 16'h07E0, 2, 1'b0, -1);
    do_reject(5, 4, 0, 0);
    do_reject(0, 240, 0, 0);
    do_reject(0, 0, 0, 320);
    do_reject(0, 0, 7, 6);
    do_fill(236, 239, 316, 319, 16'hABCD, 1, 1'b1, -1);
    do_fill(0, 239, 0, 1, 16'h1234, 1, 1'b0, -1);
    do_fill(3, 5, 7, 8, 16'h5A5A, 3, 1'b1, 14);
    do_fill(1, 2, 1, 2, 16'hC33C, 2, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      x0 = $urandom_range(235, 0);
      y0 = $urandom_range(315, 0);
      do_fill(x0, x0 + $urandom_range(3, 0), y0, y0 + $urandom_range(3, 0),
              16'($urandom), 4, i[0], -1);
      do_reject(0, $urandom_range(511, 240), 0, 0);
      do_reject(0, 0, 0, $urandom_range(511, 320));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
